// File: rtl/Wrapper_shared_pkg.sv
// Shared SPI definitions: command opcodes, slave/master state encodings and frame sizing.
package Wrapper_shared_pkg;
  localparam logic [2:0] WRITE_ADDR = 3'b000;
  localparam logic [2:0] WRITE_DATA = 3'b001;
  localparam logic [2:0] READ_ADDR  = 3'b110;
  localparam logic [2:0] READ_DATAA = 3'b111;

  localparam int FRAME_W = 11;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} SPI_slave_state_e;

  // Prefixed so both slave and master encodings can be imported together.
  typedef enum logic [2:0] {SM_IDLE, SM_SEND, SM_WAIT, SM_RECV, SM_GAP} spi_master_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == WRITE_ADDR) || (op == WRITE_DATA) || (op == READ_ADDR) || (op == READ_DATAA);
  endfunction
endpackage

// File: rtl/spi_master_seq_shifter.sv
// Frame datapath: 11-bit parallel-in/serial-out for MOSI, 8-bit serial-in/parallel-out for MISO.
module spi_frame_shifter
  import Wrapper_shared_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               shift_i,
  input  logic               sample_i,
  input  logic               miso_i,
  output logic               mosi_o,
  output logic [7:0]         rx_d_o
);
  logic [FRAME_W-1:0] tx_q;
  logic [7:0]         rx_q;

  // The shift after the last bit empties tx_q, so MOSI idles at 0 without extra muxing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load_i)       tx_q <= frame_i;
      else if (shift_i) tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
      if (sample_i)     rx_q <= rx_d_o;
    end
  end

  assign mosi_o = tx_q[FRAME_W-1];
  assign rx_d_o = {rx_q[6:0], miso_i};
endmodule

// File: rtl/spi_master_seq.sv
// SPI command sequencer: serialises {op,data} frames and collects the read byte of READ_DATAA frames.
module spi_master_seq
  import Wrapper_shared_pkg::*;
#(
  parameter int MISO_WAIT  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err,
  output logic       busy
);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MISO_WAIT - 1);
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  spi_master_state_e state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ss_n_q, cmd_ready_q, busy_q, rsp_valid_q, err_q, rd_q;
  logic [7:0]        rsp_data_q;
  logic [7:0]        rx_d;
  logic              accept, load_frame;

  assign accept     = cmd_valid && cmd_ready_q;
  assign load_frame = accept && is_legal_op(cmd_op);

  spi_frame_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_frame),
    .frame_i  ({cmd_op, cmd_data}),
    .shift_i  (state_q == SM_SEND),
    .sample_i (state_q == SM_RECV),
    .miso_i   (MISO),
    .mosi_o   (MOSI),
    .rx_d_o   (rx_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SM_IDLE;
      cnt_q       <= '0;
      ss_n_q      <= 1'b1;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        SM_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (load_frame) begin
            state_q     <= SM_SEND;
            cnt_q       <= SEND_LAST;
            ss_n_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rd_q        <= (cmd_op == READ_DATAA);
          end else if (accept) begin
            err_q <= 1'b1;
          end
        end
        SM_SEND: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rd_q) begin
            state_q <= SM_WAIT;
            cnt_q   <= WAIT_LAST;
          end else begin
            state_q <= SM_GAP;
            cnt_q   <= GAP_LAST;
            ss_n_q  <= 1'b1;
          end
        end
        SM_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= SM_RECV;
            cnt_q   <= RECV_LAST;
          end
        end
        SM_RECV: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Eighth MISO bit is taken straight from the pin on this edge.
            state_q     <= SM_GAP;
            cnt_q       <= GAP_LAST;
            ss_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_d;
          end
        end
        SM_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q     <= SM_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= SM_IDLE;
      endcase
    end
  end

  assign SS_n      = ss_n_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
endmodule
